uart_cmd_parser: RTL and testbench

- Upstream command stage of the PID motor controller.
- Consumes decoded bytes from the UART receiver and parses ASCII commands: set Kp/Ki/Kd/setpoint in hex, start auto-tune, restore default gains.
- Holds the live gain/setpoint registers that feed the PID core, and loads tuned gains when auto-tune completes.
- Emits a one-byte acknowledge toward the UART transmitter.

---
 rtl/uart_cmd_parser.sv | 121 ++++++++++++
 tb/tb_uart_cmd_parser.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: parses ASCII gain/setpoint/tune commands from the UART and holds the live PID registers
module uart_cmd_parser #(
  parameter logic [15:0] KP_DEFAULT = 16'h0100,
  parameter logic [15:0] KI_DEFAULT = 16'h0010,
  parameter logic [15:0] KD_DEFAULT = 16'h0040,
  parameter logic [15:0] SP_DEFAULT = 16'h0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        tune_busy,
  input  logic        tune_done,
  input  logic [15:0] kp_tune,
  input  logic [15:0] ki_tune,
  input  logic [15:0] kd_tune,
  output logic [15:0] kp_reg,
  output logic [15:0] ki_reg,
  output logic [15:0] kd_reg,
  output logic [15:0] setpoint,
  output logic        tune_start,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        parse_err
);
  localparam logic [7:0] ACK_OK = 8'h3E;
  localparam logic [7:0] ACK_ERR = 8'h3F;
  localparam logic [7:0] CR = 8'h0D;
  typedef enum logic [1:0] {IDLE, DIGITS, DISCARD} state_t;
  state_t state;
  logic [1:0] tgt;
  logic [15:0] acc;
  logic [2:0] cnt;
  logic hex, is_cr, bad;
  logic [3:0] nib;
  assign is_cr = rx_data == CR;
  assign hex = (rx_data >= 8'h30 && rx_data <= 8'h39) || (rx_data >= 8'h41 && rx_data <= 8'h46) ||
               (rx_data >= 8'h61 && rx_data <= 8'h66);
  assign nib = rx_data[6] ? rx_data[3:0] + 4'd9 : rx_data[3:0];
  // gain writes are refused while tuning or when tuned gains land on the same edge
  assign bad = cnt == 3'd0 || (tgt != 2'd3 && (tune_busy || tune_done));
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      kp_reg <= KP_DEFAULT;
      ki_reg <= KI_DEFAULT;
      kd_reg <= KD_DEFAULT;
      setpoint <= SP_DEFAULT;
      tune_start <= 1'b0;
      parse_err <= 1'b0;
      tx_valid <= 1'b0;
      tx_data <= 8'h00;
      state <= IDLE;
      tgt <= 2'd0;
      acc <= 16'h0000;
      cnt <= 3'd0;
    end else begin
      tune_start <= 1'b0;
      parse_err <= 1'b0;
      if (tx_ready) tx_valid <= 1'b0;
      if (tune_done) begin
        kp_reg <= kp_tune;
        ki_reg <= ki_tune;
        kd_reg <= kd_tune;
      end
      if (rx_valid) begin
        case (state)
          IDLE: begin
            if (rx_data == 8'h4B || rx_data == 8'h49 || rx_data == 8'h44 || rx_data == 8'h53) begin
              tgt <= rx_data == 8'h4B ? 2'd0 : rx_data == 8'h49 ? 2'd1 : rx_data == 8'h44 ? 2'd2 : 2'd3;
              acc <= 16'h0000;
              cnt <= 3'd0;
              state <= DIGITS;
            end else if (rx_data == 8'h54) begin
              tune_start <= !tune_busy;
              parse_err <= tune_busy;
              tx_data <= tune_busy ? ACK_ERR : ACK_OK;
              tx_valid <= 1'b1;
            end else if (rx_data == 8'h52) begin
              kp_reg <= KP_DEFAULT;
              ki_reg <= KI_DEFAULT;
              kd_reg <= KD_DEFAULT;
              tx_data <= ACK_OK;
              tx_valid <= 1'b1;
            end else if (!(is_cr || rx_data == 8'h0A || rx_data == 8'h20)) begin
              parse_err <= 1'b1;
              tx_data <= ACK_ERR;
              tx_valid <= 1'b1;
            end
          end
          DIGITS: begin
            if (hex && cnt != 3'd4) begin
              acc <= {acc[11:0], nib};
              cnt <= cnt + 3'd1;
            end else if (is_cr) begin
              state <= IDLE;
              parse_err <= bad;
              tx_data <= bad ? ACK_ERR : ACK_OK;
              tx_valid <= 1'b1;
              if (!bad && tgt == 2'd0) kp_reg <= acc;
              if (!bad && tgt == 2'd1) ki_reg <= acc;
              if (!bad && tgt == 2'd2) kd_reg <= acc;
              if (!bad && tgt == 2'd3) setpoint <= acc;
            end else begin
              state <= DISCARD;
            end
          end
          DISCARD: begin
            if (is_cr) begin
              state <= IDLE;
              parse_err <= 1'b1;
              tx_data <= ACK_ERR;
              tx_valid <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed scenario tasks with inline checks against hand-computed values
module tb_uart_cmd_parser;
  logic CLK = 0, RST_N = 0;
  logic [7:0] rx_data = 0;
  logic rx_valid = 0, tune_busy = 0, tune_done = 0, tx_ready = 1;
  logic [15:0] kp_tune = 0, ki_tune = 0, kd_tune = 0;
  logic [15:0] kp_reg, ki_reg, kd_reg, setpoint;
  logic tune_start, tx_valid, parse_err;
  logic [7:0] tx_data;
  int checks = 0, failures = 0;

  uart_cmd_parser dut (
    .CLK(CLK), .RST_N(RST_N), .rx_data(rx_data), .rx_valid(rx_valid),
    .tune_busy(tune_busy), .tune_done(tune_done),
    .kp_tune(kp_tune), .ki_tune(ki_tune), .kd_tune(kd_tune),
    .kp_reg(kp_reg), .ki_reg(ki_reg), .kd_reg(kd_reg), .setpoint(setpoint),
    .tune_start(tune_start), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .parse_err(parse_err)
  );

  always #5 CLK = ~CLK;

  // presents a byte for one edge; returns on the following negedge so results are visible
  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    rx_data = b;
    rx_valid = 1;
    @(negedge CLK);
    rx_valid = 0;
  endtask

  task automatic test_reset;
    RST_N = 0;
    repeat (2) @(negedge CLK);
    RST_N = 1;
    @(negedge CLK);
    checks++; if (kp_reg !== 16'h0100) begin failures++; $display("FAIL reset_kp got=%h exp=0100", kp_reg); end
    checks++; if (ki_reg !== 16'h0010) begin failures++; $display("FAIL reset_ki got=%h exp=0010", ki_reg); end
    checks++; if (kd_reg !== 16'h0040) begin failures++; $display("FAIL reset_kd got=%h exp=0040", kd_reg); end
    checks++; if (setpoint !== 16'h0000) begin failures++; $display("FAIL reset_sp got=%h exp=0000", setpoint); end
    checks++; if ({tx_valid, tx_data, parse_err, tune_start} !== 11'd0) begin failures++;
      $display("FAIL reset_out got=%b exp=0", {tx_valid, tx_data, parse_err, tune_start}); end
  endtask

  task automatic test_set_kp;
    send("K"); send("0"); send("2"); send("0"); send("0");
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL kp_no_early_ack got=%b exp=0", tx_valid); end
    send(8'h0D);
    checks++; if (kp_reg !== 16'h0200) begin failures++; $display("FAIL kp_set got=%h exp=0200", kp_reg); end
    checks++; if ({tx_valid, tx_data} !== {1'b1, 8'h3E}) begin failures++; $display("FAIL kp_ack got=%b/%h exp=1/3e", tx_valid, tx_data); end
    checks++; if ({ki_reg, kd_reg, setpoint} !== {16'h0010, 16'h0040, 16'h0000}) begin failures++;
      $display("FAIL kp_others got=%h/%h/%h exp=0010/0040/0000", ki_reg, kd_reg, setpoint); end
    @(negedge CLK);
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL kp_ack_once got=%b exp=0", tx_valid); end
  endtask

  task automatic test_overflow;
    int errs = 0;
    send("D"); errs += parse_err;
    send("1"); errs += parse_err;
    send("2"); errs += parse_err;
    send("3"); errs += parse_err;
    send("4"); errs += parse_err;
    send("5"); errs += parse_err;
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL ovf_no_ack_before_cr got=%b exp=0", tx_valid); end
    send(8'h0D); errs += parse_err;
    checks++; if ({tx_valid, tx_data} !== {1'b1, 8'h3F}) begin failures++; $display("FAIL ovf_ack got=%b/%h exp=1/3f", tx_valid, tx_data); end
    @(negedge CLK); errs += parse_err;
    checks++; if (errs != 1) begin failures++; $display("FAIL ovf_err_pulses got=%0d exp=1", errs); end
    checks++; if (kd_reg !== 16'h0040) begin failures++; $display("FAIL ovf_kd got=%h exp=0040", kd_reg); end
    send("I"); send("a"); send("F"); send(8'h0D);
    checks++; if (ki_reg !== 16'h00AF) begin failures++; $display("FAIL ki_set got=%h exp=00af", ki_reg); end
    checks++; if (tx_data !== 8'h3E) begin failures++; $display("FAIL ki_ack got=%h exp=3e", tx_data); end
  endtask

  task automatic test_edges;
    send("K"); send(8'h0D);
    checks++; if ({tx_data, parse_err} !== {8'h3F, 1'b1}) begin failures++; $display("FAIL empty_cmd got=%h/%b exp=3f/1", tx_data, parse_err); end
    send("S"); send("1"); send("g"); send(8'h0D);
    checks++; if ({tx_data, setpoint} !== {8'h3F, 16'h0000}) begin failures++; $display("FAIL bad_digit got=%h/%h exp=3f/0000", tx_data, setpoint); end
    send(8'h0A); send(" ");
    checks++; if ({tx_valid, parse_err} !== 2'b00) begin failures++; $display("FAIL ignore_ws got=%b exp=00", {tx_valid, parse_err}); end
  endtask

  task automatic test_tune;
    tune_busy = 0;
    send("T");
    checks++; if ({tune_start, tx_data, parse_err} !== {1'b1, 8'h3E, 1'b0}) begin failures++;
      $display("FAIL tune_go got=%b/%h/%b exp=1/3e/0", tune_start, tx_data, parse_err); end
    @(negedge CLK);
    checks++; if (tune_start !== 1'b0) begin failures++; $display("FAIL tune_pulse got=%b exp=0", tune_start); end
    tune_busy = 1;
    send("T");
    checks++; if ({tune_start, tx_data, parse_err} !== {1'b0, 8'h3F, 1'b1}) begin failures++;
      $display("FAIL tune_busy got=%b/%h/%b exp=0/3f/1", tune_start, tx_data, parse_err); end
    send("K"); send("5"); send(8'h0D);
    checks++; if ({kp_reg, tx_data} !== {16'h0200, 8'h3F}) begin failures++; $display("FAIL busy_kp got=%h/%h exp=0200/3f", kp_reg, tx_data); end
    send("S"); send("5"); send(8'h0D);
    checks++; if ({setpoint, tx_data} !== {16'h0005, 8'h3E}) begin failures++; $display("FAIL busy_sp got=%h/%h exp=0005/3e", setpoint, tx_data); end
    tune_busy = 0;
  endtask

  task automatic test_tune_done_collision;
    send("K"); send("1");
    @(negedge CLK);
    rx_data = 8'h0D; rx_valid = 1; tune_done = 1;
    kp_tune = 16'h0333; ki_tune = 16'h0444; kd_tune = 16'h0555;
    @(negedge CLK);
    rx_valid = 0; tune_done = 0;
    checks++; if ({kp_reg, ki_reg, kd_reg} !== {16'h0333, 16'h0444, 16'h0555}) begin failures++;
      $display("FAIL tdone_gains got=%h/%h/%h exp=0333/0444/0555", kp_reg, ki_reg, kd_reg); end
    checks++; if ({tx_data, parse_err} !== {8'h3F, 1'b1}) begin failures++; $display("FAIL tdone_ack got=%h/%b exp=3f/1", tx_data, parse_err); end
  endtask

  task automatic test_back_to_back;
    tx_ready = 0;
    send("S"); send("F"); send("F"); send(8'h0D);
    checks++; if (setpoint !== 16'h00FF) begin failures++; $display("FAIL hold_sp got=%h exp=00ff", setpoint); end
    repeat (3) @(negedge CLK);
    checks++; if ({tx_valid, tx_data} !== {1'b1, 8'h3E}) begin failures++; $display("FAIL hold_ack got=%b/%h exp=1/3e", tx_valid, tx_data); end
    send("Q");
    checks++; if ({tx_valid, tx_data} !== {1'b1, 8'h3F}) begin failures++; $display("FAIL overwrite_err got=%b/%h exp=1/3f", tx_valid, tx_data); end
    send("R");
    checks++; if ({tx_valid, tx_data} !== {1'b1, 8'h3E}) begin failures++; $display("FAIL overwrite_ok got=%b/%h exp=1/3e", tx_valid, tx_data); end
    checks++; if ({kp_reg, ki_reg, kd_reg, setpoint} !== {16'h0100, 16'h0010, 16'h0040, 16'h00FF}) begin failures++;
      $display("FAIL restore got=%h/%h/%h/%h exp=0100/0010/0040/00ff", kp_reg, ki_reg, kd_reg, setpoint); end
    tx_ready = 1;
    @(negedge CLK);
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL handshake_drop got=%b exp=0", tx_valid); end
  endtask

  task automatic test_reset_mid;
    send("K"); send("7");
    @(negedge CLK);
    RST_N = 0;
    @(negedge CLK);
    RST_N = 1;
    checks++; if ({kp_reg, setpoint, tx_valid} !== {16'h0100, 16'h0000, 1'b0}) begin failures++;
      $display("FAIL mid_reset got=%h/%h/%b exp=0100/0000/0", kp_reg, setpoint, tx_valid); end
    send("3");
    checks++; if ({tx_valid, tx_data, parse_err} !== {1'b1, 8'h3F, 1'b1}) begin failures++;
      $display("FAIL post_reset_digit got=%b/%h/%b exp=1/3f/1", tx_valid, tx_data, parse_err); end
    send(8'h0D);
    checks++; if ({kp_reg, tx_valid} !== {16'h0100, 1'b0}) begin failures++; $display("FAIL post_reset_cr got=%h/%b exp=0100/0", kp_reg, tx_valid); end
  endtask

  initial begin
    test_reset;
    test_set_kp;
    test_overflow;
    test_edges;
    test_tune;
    test_tune_done_collision;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
